clk_divider_multi: RTL and testbench
====================================

// Module: clk_divider_multi
// PURPOSE
//   Parametrised multi-channel clock divider: derives NUM_CH slow clock-enables/clocks from the
//   fast memory clk, each with its own runtime-programmable ratio, per-channel enable, and
//   glitch-free ratio change / stop at period boundaries. Drives axi_slave and other DLA-side
//   slow domains in the synth testbench; successor to the fixed single-ratio divider.
// PARAMETERS
//   NUM_CH       2   number of independent divider channels
//   CNT_W        8   width of ratio and phase counters per channel
//   DEFAULT_DIV  4   ratio loaded into active and shadow registers at reset (>=2)
// PORTS
//   clk           in   1             fast (memory) clock; all logic on posedge
//   reset         in   1             synchronous, active-low reset
//   ch_en         in   NUM_CH        per-channel run enable (level)
//   div_ratio     in   NUM_CH*CNT_W  per-channel requested ratio N, channel i at [i*CNT_W +: CNT_W]
//   div_load      in   NUM_CH        1-cycle pulse: capture div_ratio slice i into shadow[i]
//   slow_clk      out  NUM_CH        divided clocks, registered
//   rise_pulse    out  NUM_CH        1-cycle high in the same cycle slow_clk[i] goes 0/OFF->1
//   ch_active     out  NUM_CH        channel in HIGH or LOW state (not OFF)
// BEHAVIOUR
//   - Reset (reset==0 at posedge): slow_clk=0, rise_pulse=0, ch_active=0, all FSMs OFF,
//     cnt=0, active_div=shadow_div=DEFAULT_DIV. Reset mid-period aborts immediately, no finish.
//   - Ratio clamp: N<2 (0 or 1) treated as 2. Period=N clk cycles; high phase H=ceil(N/2),
//     low phase L=floor(N/2) (N=5 -> 3 high/2 low; N=2 -> 1/1).
//   - div_load[i]: shadow[i]<=clamp(div_ratio slice) next cycle; never alters active_div mid-period.
//     Load and apply in the same cycle: shadow written, apply uses the OLD shadow value.
//   - Per-channel FSM {OFF, HIGH, LOW}, down-counter cnt:
//     OFF : ch_en=1 (and start permitted, see CONFIGURATION) -> HIGH, active_div<=shadow,
//           cnt<=H-1, slow_clk<=1, rise_pulse<=1. Latency: slow_clk high 1 cycle after ch_en seen.
//     HIGH: cnt!=0 -> cnt-1; cnt==0 -> LOW, cnt<=L-1, slow_clk<=0. ch_en ignored in HIGH.
//     LOW : cnt!=0 -> cnt-1; cnt==0: ch_en=1 -> HIGH with active_div<=shadow, cnt<=H'-1,
//           slow_clk<=1, rise_pulse<=1; ch_en=0 -> OFF, slow_clk stays 0.
//   - Stop is glitch-free: dropping ch_en completes current period (full low phase) before OFF.
//   - ch_active = (state!=OFF), registered with state. rise_pulse low in all other cycles.
//   - Channels fully independent except under CLK_DIV_ALIGN_EN.
//   - Counter arithmetic in CNT_W bits; H-1, L-1 always >=0 after clamp; no wrap possible.
// CONFIGURATION
//   CLK_DIV_ALIGN_EN defined: channel i>0 leaving OFF waits for align_go, where align_go =
//     ch0 about to rise this cycle (ch0 OFF & ch_en[0] & permitted, or ch0 LOW & cnt==0 &
//     ch_en[0]); its first rise_pulse coincides with ch0's rise. If ch0 is OFF and ch_en[0]=0,
//     channel i starts immediately (no deadlock). Channel 0 is never delayed.
//   CLK_DIV_ALIGN_EN undefined: every channel starts 1 cycle after ch_en sampled, no alignment
//     logic synthesised.
// TESTING
//   1. DEFAULT_DIV=4, ch_en=01 after reset -> slow_clk[0]=1,1,0,0 repeating; rise_pulse[0] every 4th cycle; ch1 stays 0.
//   2. div_ratio[0]=5 + div_load, then ch_en[0]=1 -> 3 high/2 low; ratio 1 and 0 -> 1 high/1 low (clamp 2).
//   3. Running at N=4, load N=6 during HIGH -> current period exactly 4 cycles, next periods 6 (3/3).
//   4. Drop ch_en[0] in cycle 1 of HIGH (N=4) -> 2 high, 2 low, then OFF: slow_clk=0, ch_active=0, no rise.
//   5. Assert reset mid-HIGH -> next posedge all outputs 0, active_div=4; release+ch_en -> restarts at N=4.
//   6. ALIGN_EN: ch0 N=4 running, ch1 N=8 enabled mid-ch0-period -> ch1 rise_pulse same cycle as ch0's next rise; without macro, 1 cycle after ch_en.

Source files
------------

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH runtime-programmable clock dividers, glitch-free start/stop/ratio change.
// Optional CLK_DIV_ALIGN_EN: channels i>0 start in phase with channel 0's rising edge.
module clk_divider_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       slow_clk,
    output logic [NUM_CH-1:0]       rise_pulse,
    output logic [NUM_CH-1:0]       ch_active
);
    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [NUM_CH-1:0] start_ok;
`ifdef CLK_DIV_ALIGN_EN
    logic align_go;
    logic ch0_idle;
    assign align_go = ch_en[0] & ((g_ch[0].st == OFF) | (g_ch[0].st == LOW && g_ch[0].cnt == '0));
    assign ch0_idle = (g_ch[0].st == OFF) & ~ch_en[0];
    always_comb begin
        start_ok    = {NUM_CH{align_go | ch0_idle}};
        start_ok[0] = 1'b1;
    end
`else
    assign start_ok = '1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt, active_div, shadow, req, h_m1, l_m1;
        logic             rise, slow_q, rise_q, act_q;
        assign req  = div_ratio[i*CNT_W +: CNT_W];
        // new period takes its high length from shadow, low length from the ratio it started with
        assign h_m1 = (shadow - ONE) >> 1;
        assign l_m1 = (active_div >> 1) - ONE;
        assign rise = ch_en[i] & (((st == OFF) & start_ok[i]) | (st == LOW && cnt == '0));
        always_ff @(posedge clk) begin
            if (!reset) begin
                st         <= OFF;
                cnt        <= '0;
                active_div <= DEF;
                shadow     <= DEF;
                slow_q     <= 1'b0;
                rise_q     <= 1'b0;
                act_q      <= 1'b0;
            end else begin
                if (div_load[i]) shadow <= (req < TWO) ? TWO : req;
                rise_q <= rise;
                if (rise) begin
                    st         <= HIGH;
                    active_div <= shadow;
                    cnt        <= h_m1;
                    slow_q     <= 1'b1;
                    act_q      <= 1'b1;
                end else if (st == HIGH && cnt == '0) begin
                    st     <= LOW;
                    cnt    <= l_m1;
                    slow_q <= 1'b0;
                end else if (st == LOW && cnt == '0) begin
                    st    <= OFF;
                    act_q <= 1'b0;
                end else if (st != OFF) begin
                    cnt <= cnt - ONE;
                end
            end
        end
        assign slow_clk[i]   = slow_q;
        assign rise_pulse[i] = rise_q;
        assign ch_active[i]  = act_q;
    end
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: directed checks of clk_divider_multi (2 channels, CNT_W=8, DEFAULT_DIV=4).
module tb_clk_divider_multi;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_en;
    logic [15:0] div_ratio;
    logic [1:0]  div_load;
    logic [1:0]  slow_clk, rise_pulse, ch_active;
    int tests = 0;
    int fails = 0;

    clk_divider_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clk(clk), .reset(reset), .ch_en(ch_en), .div_ratio(div_ratio),
        .div_load(div_load), .slow_clk(slow_clk), .rise_pulse(rise_pulse),
        .ch_active(ch_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // patterns are read left-to-right in time order: bit n-1 is the first cycle
    task automatic seq(input string tag, input int ch, input int n,
                       input logic [31:0] s_exp, input logic [31:0] r_exp, input logic [31:0] a_exp);
        logic [31:0] s, r, a;
        s = s_exp; r = r_exp; a = a_exp;
        for (int k = 0; k < n; k++) begin
            step();
            chk($sformatf("%s slow[%0d] c%0d", tag, ch, k), 32'(slow_clk[ch]), 32'(s[n-1-k]));
            chk($sformatf("%s rise[%0d] c%0d", tag, ch, k), 32'(rise_pulse[ch]), 32'(r[n-1-k]));
            chk($sformatf("%s act[%0d] c%0d", tag, ch, k), 32'(ch_active[ch]), 32'(a[n-1-k]));
        end
    endtask

    task automatic load0(input logic [7:0] n);
        div_ratio[7:0] = n;
        div_load = 2'b01;
        step();
        div_load = 2'b00;
    endtask

    initial begin
        reset = 1'b0; ch_en = 2'b00; div_ratio = '0; div_load = 2'b00;
        step(); step();
        chk("rst slow", 32'(slow_clk), 0);
        chk("rst rise", 32'(rise_pulse), 0);
        chk("rst act", 32'(ch_active), 0);
        reset = 1'b1;
        ch_en = 2'b01;
        seq("default", 0, 8, 32'b11001100, 32'b10001000, 32'b11111111);
        chk("ch1 idle slow", 32'(slow_clk[1]), 0);
        chk("ch1 idle act", 32'(ch_active[1]), 0);
        ch_en = 2'b00;
        step();
        chk("stop act", 32'(ch_active[0]), 0);
        // odd ratio 5: 3 high, 2 low
        load0(8'd5);
        ch_en = 2'b01;
        seq("n5", 0, 10, 32'b1110011100, 32'b1000010000, 32'b1111111111);
        ch_en = 2'b00;
        step();
        load0(8'd1);
        ch_en = 2'b01;
        seq("n1clamp", 0, 6, 32'b101010, 32'b101010, 32'b111111);
        ch_en = 2'b00;
        step();
        load0(8'd0);
        ch_en = 2'b01;
        seq("n0clamp", 0, 6, 32'b101010, 32'b101010, 32'b111111);
        ch_en = 2'b00;
        step();
        // ratio change during HIGH lands at the next period boundary
        load0(8'd4);
        ch_en = 2'b01;
        step();
        chk("n4 start", 32'(rise_pulse[0]), 1);
        div_ratio[7:0] = 8'd6;
        div_load = 2'b01;
        seq("n4to6a", 0, 1, 32'b1, 32'b0, 32'b1);
        div_load = 2'b00;
        seq("n4to6b", 0, 9, 32'b001110001, 32'b001000001, 32'b111111111);
        // reset while in HIGH of a 6-period
        reset = 1'b0;
        step();
        chk("midrst slow", 32'(slow_clk), 0);
        chk("midrst rise", 32'(rise_pulse), 0);
        chk("midrst act", 32'(ch_active), 0);
        reset = 1'b1;
        seq("post rst n4", 0, 8, 32'b11001100, 32'b10001000, 32'b11111111);
        // drop enable in first HIGH cycle: period completes, then OFF
        seq("stop rise", 0, 1, 32'b1, 32'b1, 32'b1);
        ch_en = 2'b00;
        seq("stop tail", 0, 5, 32'b10000, 32'b00000, 32'b11100);
        // ch1 at N=8 enabled mid-ch0-period
        div_ratio = {8'd8, 8'd4};
        div_load = 2'b10;
        step();
        div_load = 2'b00;
        ch_en = 2'b01;
        step();
        step();
        ch_en = 2'b11;
`ifdef CLK_DIV_ALIGN_EN
        seq("ch1 align", 1, 6, 32'b001111, 32'b001000, 32'b001111);
`else
        seq("ch1 free", 1, 6, 32'b111100, 32'b100000, 32'b111111);
`endif
        ch_en = 2'b00;
        for (int k = 0; k < 10; k++) step();
        chk("all off", 32'(ch_active), 0);
        // load and apply in the same cycle: first period uses the old shadow (4)
        div_ratio[7:0] = 8'd2;
        div_load = 2'b01;
        ch_en = 2'b01;
        step();
        div_load = 2'b00;
        chk("ldapply rise", 32'(rise_pulse[0]), 1);
        chk("ldapply slow", 32'(slow_clk[0]), 1);
        seq("ldapply", 0, 7, 32'b1001010, 32'b0001010, 32'b1111111);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
